move_scheduler: RTL and testbench

//  Sequences one movement step per game tick for every actor (pac-man + ghosts) through the single

---
 rtl/move_scheduler_pkg.sv | 33 +++
 rtl/move_scheduler_if.sv | 34 +++
 rtl/move_scheduler_tick_divider.sv | 26 ++
 rtl/move_scheduler.sv | 140 ++++++++++++++
 tb/tb_move_scheduler.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/move_scheduler_pkg.sv
// Shared definitions for the per-tick actor movement sequencer: direction codes,
// map bounds and FSM state encodings.
package move_scheduler_pkg;

    typedef logic [7:0] coord_x_t;
    typedef logic [6:0] coord_y_t;
    typedef logic [2:0] actor_id_t;

    typedef enum logic [2:0] {
        DIR_RIGHT = 3'd0,
        DIR_UP    = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_DOWN  = 3'd3,
        DIR_WAIT  = 3'd4
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int X_MAX_DEF = 26;
    localparam int Y_MAX_DEF = 23;

    // Only the four compass codes move; WAIT and the unused codes 5..7 stay put.
    function automatic logic is_move(input logic [2:0] d);
        return d <= 3'(DIR_DOWN);
    endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// Actor-side and map_lut-side signals of the movement sequencer, grouped with
// the scheduler as master and the actor/map environment as slave.
interface move_scheduler_if;
    import move_scheduler_pkg::*;

    logic      enable;
    coord_x_t  pos_x;
    coord_y_t  pos_y;
    logic [2:0] dir;
    actor_id_t act_id;
    coord_x_t  map_x;
    coord_y_t  map_y;
    logic      map_q;
    logic      upd_valid;
    coord_x_t  upd_x;
    coord_y_t  upd_y;
    logic      upd_blocked;
    logic      busy;
    logic      done;
    logic      overrun;

    modport master (
        input  enable, pos_x, pos_y, dir, map_q,
        output act_id, map_x, map_y, upd_valid, upd_x, upd_y, upd_blocked,
               busy, done, overrun
    );

    modport slave (
        output enable, pos_x, pos_y, dir, map_q,
        input  act_id, map_x, map_y, upd_valid, upd_x, upd_y, upd_blocked,
               busy, done, overrun
    );

endinterface

// File: rtl/move_scheduler_tick_divider.sv
// Free-running 0..TICK_DIV-1 counter; tick is high while the counter sits on its last value.
module move_scheduler_tick_divider #(
    parameter int TICK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == CW'(TICK_DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CW'(TICK_DIV - 1));

endmodule

// File: rtl/move_scheduler.sv
// Walks every actor through one move per game tick using the single shared map_lut:
// candidate cell with tunnel wrap, wall lookup, then commit or hold.
module move_scheduler
    import move_scheduler_pkg::*;
#(
    parameter int N_ACTORS = 5,
    parameter int TICK_DIV = 4,
    parameter int MAP_LAT  = 1,
    parameter int X_MAX    = X_MAX_DEF,
    parameter int Y_MAX    = Y_MAX_DEF
) (
    input logic               clock,
    input logic               reset,
    move_scheduler_if.master  bus
);

    localparam int WCW = (MAP_LAT > 1) ? $clog2(MAP_LAT) : 1;

    logic           tick;
    state_e         state;
    logic [WCW-1:0] wait_cnt;
    actor_id_t      act_id;
    coord_x_t       cand_x, cx_q, px_q, upd_x;
    coord_y_t       cand_y, cy_q, py_q, upd_y;
    logic           mv_q, upd_valid, upd_blocked, busy, done;

    move_scheduler_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // Wrap check runs on the modular result: stepping past either edge lands above the max.
    always_comb begin
        cand_x = bus.pos_x;
        cand_y = bus.pos_y;
        case (bus.dir)
            3'(DIR_RIGHT): begin
                cand_x = bus.pos_x + 8'd1;
                if (cand_x > 8'(X_MAX)) cand_x = '0;
            end
            3'(DIR_LEFT): begin
                cand_x = bus.pos_x - 8'd1;
                if (cand_x > 8'(X_MAX)) cand_x = 8'(X_MAX);
            end
            3'(DIR_UP): begin
                cand_y = bus.pos_y - 7'd1;
                if (cand_y > 7'(Y_MAX)) cand_y = 7'(Y_MAX);
            end
            3'(DIR_DOWN): begin
                cand_y = bus.pos_y + 7'd1;
                if (cand_y > 7'(Y_MAX)) cand_y = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            act_id      <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            upd_valid   <= 1'b0;
            upd_x       <= '0;
            upd_y       <= '0;
            upd_blocked <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            upd_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick && bus.enable) begin
                        state  <= ST_ISSUE;
                        act_id <= '0;
                        busy   <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    px_q     <= bus.pos_x;
                    py_q     <= bus.pos_y;
                    mv_q     <= is_move(bus.dir);
                    cx_q     <= cand_x;
                    cy_q     <= cand_y;
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // map_q now answers the lookup presented during ISSUE.
                    if (wait_cnt == WCW'(MAP_LAT - 1)) begin
                        upd_valid <= 1'b1;
                        if (mv_q && bus.map_q) begin
                            upd_x       <= px_q;
                            upd_y       <= py_q;
                            upd_blocked <= 1'b1;
                        end else begin
                            upd_x       <= cx_q;
                            upd_y       <= cy_q;
                            upd_blocked <= 1'b0;
                        end
                        state <= ST_COMMIT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (act_id == 3'(N_ACTORS - 1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        act_id <= act_id + 1'b1;
                        state  <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    act_id <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The lookup is presented straight from the live position during ISSUE, then held.
    assign bus.map_x       = (state == ST_ISSUE) ? cand_x : cx_q;
    assign bus.map_y       = (state == ST_ISSUE) ? cand_y : cy_q;
    assign bus.act_id      = act_id;
    assign bus.upd_valid   = upd_valid;
    assign bus.upd_x       = upd_x;
    assign bus.upd_y       = upd_y;
    assign bus.upd_blocked = upd_blocked;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.overrun     = tick && bus.enable && !reset && (state != ST_IDLE);

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench: single-actor move table plus full-sweep, overrun, pause and abort sequences.
module tb_move_scheduler;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    move_scheduler_if ifa ();
    move_scheduler_if ifb ();

    // Single actor, generous tick period.
    move_scheduler #(.N_ACTORS(1), .TICK_DIV(8), .MAP_LAT(1), .X_MAX(26), .Y_MAX(23)) dut_a (
        .clock (clk),
        .reset (rst_a),
        .bus   (ifa.master)
    );

    // Five actors with a tick period far too short, so ticks overrun.
    move_scheduler #(.N_ACTORS(5), .TICK_DIV(4), .MAP_LAT(1), .X_MAX(26), .Y_MAX(23)) dut_b (
        .clock (clk),
        .reset (rst_b),
        .bus   (ifb.master)
    );

    logic [7:0] ax;
    logic [6:0] ay;
    logic [2:0] ad;
    logic       wall_en;
    logic [7:0] wall_x;
    logic [6:0] wall_y;
    logic [7:0] bx [8];
    logic [6:0] by [8];
    logic [2:0] bd [8];

    assign ifa.pos_x = ax;
    assign ifa.pos_y = ay;
    assign ifa.dir   = ad;
    assign ifb.pos_x = bx[ifb.act_id];
    assign ifb.pos_y = by[ifb.act_id];
    assign ifb.dir   = bd[ifb.act_id];

    // One-cycle-latency map ROMs.
    always @(posedge clk) ifa.map_q <= wall_en && (ifa.map_x == wall_x) && (ifa.map_y == wall_y);
    always @(posedge clk) ifb.map_q <= (ifb.map_x == 8'd6) && (ifb.map_y == 7'd4);

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] d;
        logic       wall;
        logic [7:0] mx;
        logic [6:0] my;
        logic [7:0] ux;
        logic [6:0] uy;
        logic       blk;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic wait_busy_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (ifa.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("busy_a_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_busy_b(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (ifb.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("busy_b_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [7:0] exp_mx [5];
        logic [6:0] exp_my [5];
        logic [7:0] exp_ux [5];
        logic [6:0] exp_uy [5];
        logic       exp_bk [5];
        int cnt_upd, cnt_done, cnt_ovr, cnt_busy;
        bit ok;

        //                x      y    dir  wall  map_x  map_y  upd_x  upd_y  blk
        vecs[0]  = '{8'd5,  7'd5,  3'd0, 1'b0, 8'd6,  7'd5,  8'd6,  7'd5,  1'b0};
        vecs[1]  = '{8'd5,  7'd5,  3'd1, 1'b1, 8'd5,  7'd4,  8'd5,  7'd5,  1'b1};
        vecs[2]  = '{8'd26, 7'd11, 3'd0, 1'b0, 8'd0,  7'd11, 8'd0,  7'd11, 1'b0};
        vecs[3]  = '{8'd0,  7'd11, 3'd2, 1'b0, 8'd26, 7'd11, 8'd26, 7'd11, 1'b0};
        vecs[4]  = '{8'd3,  7'd0,  3'd1, 1'b0, 8'd3,  7'd23, 8'd3,  7'd23, 1'b0};
        vecs[5]  = '{8'd4,  7'd23, 3'd3, 1'b0, 8'd4,  7'd0,  8'd4,  7'd0,  1'b0};
        vecs[6]  = '{8'd10, 7'd10, 3'd4, 1'b1, 8'd10, 7'd10, 8'd10, 7'd10, 1'b0};
        vecs[7]  = '{8'd7,  7'd8,  3'd6, 1'b1, 8'd7,  7'd8,  8'd7,  7'd8,  1'b0};
        vecs[8]  = '{8'd30, 7'd100,3'd4, 1'b0, 8'd30, 7'd100,8'd30, 7'd100,1'b0};
        vecs[9]  = '{8'd0,  7'd0,  3'd2, 1'b1, 8'd26, 7'd0,  8'd0,  7'd0,  1'b1};
        vecs[10] = '{8'd12, 7'd9,  3'd3, 1'b0, 8'd12, 7'd10, 8'd12, 7'd10, 1'b0};

        // Sweep actors R,U,L,D,WAIT; actor 1 hits the wall at (6,4).
        bx[0] = 8'd1;  by[0] = 7'd1;  bd[0] = 3'd0;
        bx[1] = 8'd6;  by[1] = 7'd5;  bd[1] = 3'd1;
        bx[2] = 8'd9;  by[2] = 7'd9;  bd[2] = 3'd2;
        bx[3] = 8'd20; by[3] = 7'd23; bd[3] = 3'd3;
        bx[4] = 8'd13; by[4] = 7'd13; bd[4] = 3'd4;
        for (int i = 5; i < 8; i++) begin
            bx[i] = '0; by[i] = '0; bd[i] = 3'd4;
        end
        exp_mx = '{8'd2, 8'd6, 8'd8, 8'd20, 8'd13};
        exp_my = '{7'd1, 7'd4, 7'd9, 7'd0,  7'd13};
        exp_ux = '{8'd2, 8'd6, 8'd8, 8'd20, 8'd13};
        exp_uy = '{7'd1, 7'd5, 7'd9, 7'd0,  7'd13};
        exp_bk = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        ax = '0; ay = '0; ad = 3'd4;
        wall_en = 1'b0; wall_x = '0; wall_y = '0;
        ifa.enable = 1'b0;
        ifb.enable = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs_a", {ifa.act_id, ifa.map_x, ifa.map_y, ifa.upd_valid, ifa.upd_x, ifa.upd_y,
                               ifa.upd_blocked, ifa.busy, ifa.done, ifa.overrun}, 64'd0);
        check("reset_outs_b", {ifb.act_id, ifb.map_x, ifb.map_y, ifb.upd_valid, ifb.upd_x, ifb.upd_y,
                               ifb.upd_blocked, ifb.busy, ifb.done, ifb.overrun}, 64'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        cnt_upd = 0; cnt_busy = 0; cnt_ovr = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cnt_upd  += int'(ifa.upd_valid) + int'(ifb.upd_valid);
            cnt_busy += int'(ifa.busy) + int'(ifb.busy);
            cnt_ovr  += int'(ifa.overrun) + int'(ifb.overrun);
        end
        check("idle_after_reset_upd", 64'(cnt_upd), 64'd0);
        check("idle_after_reset_busy_ovr", 64'(cnt_busy + cnt_ovr), 64'd0);

        // Single-actor table.
        for (int v = 0; v < 11; v++) begin
            ax = vecs[v].x; ay = vecs[v].y; ad = vecs[v].d;
            wall_en = vecs[v].wall; wall_x = vecs[v].mx; wall_y = vecs[v].my;
            ifa.enable = 1'b1;
            wait_busy_a(ok);
            ifa.enable = 1'b0;
            if (ok) begin
                check($sformatf("v%0d_issue", v), {ifa.act_id, ifa.upd_valid, ifa.map_x, ifa.map_y},
                      {3'd0, 1'b0, vecs[v].mx, vecs[v].my});
                @(negedge clk);
                ax = 8'd99; ay = 7'd99; ad = 3'd2;
                check($sformatf("v%0d_wait", v), {ifa.upd_valid, ifa.map_x, ifa.map_y},
                      {1'b0, vecs[v].mx, vecs[v].my});
                @(negedge clk);
                check($sformatf("v%0d_commit", v), {ifa.upd_valid, ifa.upd_x, ifa.upd_y, ifa.upd_blocked},
                      {1'b1, vecs[v].ux, vecs[v].uy, vecs[v].blk});
                @(negedge clk);
                check($sformatf("v%0d_done", v), {ifa.done, ifa.busy, ifa.upd_valid}, {1'b1, 1'b0, 1'b0});
            end
            repeat (2) @(negedge clk);
        end

        // Five-actor sweep with overrunning ticks.
        ifb.enable = 1'b1;
        wait_busy_b(ok);
        if (ok) begin
            cnt_upd = 0; cnt_done = 0; cnt_ovr = 0;
            for (int k = 0; k < 16; k++) begin
                if (k > 0) @(negedge clk);
                cnt_upd  += int'(ifb.upd_valid);
                cnt_done += int'(ifb.done);
                cnt_ovr  += int'(ifb.overrun);
                if (k < 15 && (k % 3) == 0)
                    check($sformatf("sweep_issue%0d", k / 3), {ifb.act_id, ifb.map_x, ifb.map_y, ifb.busy},
                          {3'(k / 3), exp_mx[k / 3], exp_my[k / 3], 1'b1});
                if (k < 15 && (k % 3) == 2)
                    check($sformatf("sweep_commit%0d", k / 3),
                          {ifb.upd_valid, ifb.act_id, ifb.upd_x, ifb.upd_y, ifb.upd_blocked},
                          {1'b1, 3'(k / 3), exp_ux[k / 3], exp_uy[k / 3], exp_bk[k / 3]});
                if (k == 15)
                    check("sweep_done_slot", {ifb.done, ifb.busy}, {1'b1, 1'b0});
            end
            check("sweep_upd_count", 64'(cnt_upd), 64'd5);
            check("sweep_done_count", 64'(cnt_done), 64'd1);
            check("sweep_overrun_count", 64'(cnt_ovr), 64'd4);
            @(negedge clk);
            ifb.enable = 1'b0;
            check("sweep_idle_after", {ifb.busy, ifb.done, ifb.upd_valid}, 3'd0);
        end

        // Paused: ticks keep coming but nothing starts and nothing overruns.
        cnt_upd = 0; cnt_busy = 0; cnt_ovr = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cnt_upd  += int'(ifb.upd_valid);
            cnt_busy += int'(ifb.busy);
            cnt_ovr  += int'(ifb.overrun);
        end
        check("pause_no_activity", {32'(cnt_upd), 16'(cnt_busy), 16'(cnt_ovr)}, 64'd0);

        // Reset while actor 0 waits on the map.
        ifb.enable = 1'b1;
        wait_busy_b(ok);
        ifb.enable = 1'b0;
        if (ok) begin
            @(negedge clk);
            rst_b = 1'b1;
            @(negedge clk);
            rst_b = 1'b0;
            check("abort_idle", {ifb.busy, ifb.upd_valid, ifb.act_id, ifb.done}, 6'd0);
            cnt_upd = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                cnt_upd += int'(ifb.upd_valid) + int'(ifb.busy);
            end
            check("abort_no_commit", 64'(cnt_upd), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
